// File: rtl/dmux_nway_stream.sv
// dmux_nway_stream: registered 1-to-N stream demultiplexer with broadcast.
// Each output channel owns a one-entry buffer, so a stalled consumer only
// blocks traffic addressed to it (and broadcasts). Out-of-range selects are
// accepted, discarded, flagged on drop_pulse and counted in drop_count.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   in_valid     input word present
//   in_ready     combinational: input word can be accepted this cycle
//   in_data      input word (WIDTH bits)
//   in_sel       target channel (SEL_W bits)
//   in_bcast     deliver to every channel, in_sel ignored
//   out_valid    per-channel word-present flag
//   out_ready    per-channel consumer ready
//   out_data     channel k in bits [k*WIDTH +: WIDTH]
//   drop_pulse   one-cycle pulse after an out-of-range word is accepted
//   drop_count   saturating count of dropped words
module dmux_nway_stream #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = $clog2(CHANNELS),
  parameter int unsigned ERR_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_bcast,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      drop_pulse,
  output logic [ERR_W-1:0]          drop_count
);

  // Full select space, so in_sel can index without running past CHANNELS.
  localparam int unsigned SEL_SPAN = 1 << SEL_W;

  logic [CHANNELS-1:0]       out_valid_q, out_valid_d;
  logic [CHANNELS*WIDTH-1:0] out_data_q, out_data_d;
  logic                      drop_pulse_q, drop_pulse_d;
  logic [ERR_W-1:0]          drop_count_q, drop_count_d;

  logic [CHANNELS-1:0]       can_take;
  logic [SEL_SPAN-1:0]       can_take_span;
  logic [CHANNELS-1:0]       load;
  logic                      sel_in_range;
  logic                      accept;
  logic                      drop;

  // Acceptance: a buffer can take a word if empty or being drained this cycle.
  always_comb begin
    can_take      = ~out_valid_q | out_ready;
    can_take_span = SEL_SPAN'(can_take);
    sel_in_range  = ({1'b0, in_sel} < (SEL_W + 1)'(CHANNELS));
    in_ready      = 1'b1;
    if (in_bcast) begin
      in_ready = &can_take;
    end else if (sel_in_range) begin
      in_ready = can_take_span[in_sel];
    end
    accept = in_valid & in_ready;
    drop   = accept & ~in_bcast & ~sel_in_range;
    load   = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      load[k] = accept & (in_bcast | (sel_in_range & (in_sel == SEL_W'(k))));
    end
  end

  // Next state: load wins over drain; drained data is left in place.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    drop_pulse_d = drop;
    drop_count_d = drop_count_q;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (load[k]) begin
        out_valid_d[k]                 = 1'b1;
        out_data_d[k*WIDTH +: WIDTH]   = in_data;
      end else if (out_ready[k]) begin
        out_valid_d[k]                 = 1'b0;
      end
    end
    if (drop && (drop_count_q != {ERR_W{1'b1}})) begin
      drop_count_d = drop_count_q + ERR_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= '0;
      out_data_q   <= '0;
      drop_pulse_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      drop_pulse_q <= drop_pulse_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign drop_pulse = drop_pulse_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_dmux_nway_stream.sv
// tb_dmux_nway_stream: self-checking bench for dmux_nway_stream.
// Main DUT: WIDTH=8, CHANNELS=4. Two CHANNELS=3 DUTs (ERR_W=8 and ERR_W=2)
// share stimulus for the out-of-range drop and saturation cases.
`timescale 1ns/1ps
module tb_dmux_nway_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main DUT signals
  logic        in_valid, in_ready, in_bcast;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid, out_ready;
  logic [31:0] out_data;
  logic        drop_pulse;
  logic [7:0]  drop_count;

  // Shared stimulus for the CHANNELS=3 DUTs
  logic        c_valid, c_bcast;
  logic [7:0]  c_data;
  logic [1:0]  c_sel;
  logic [2:0]  c_oready;
  logic        a_ready, b_ready, a_drop, b_drop;
  logic [2:0]  a_valid, b_valid;
  logic [23:0] a_data, b_data;
  logic [7:0]  a_count;
  logic [1:0]  b_count;

  dmux_nway_stream #(.WIDTH(8), .CHANNELS(4), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_pulse(drop_pulse), .drop_count(drop_count)
  );

  dmux_nway_stream #(.WIDTH(8), .CHANNELS(3), .ERR_W(8)) dut_c3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_valid), .in_ready(a_ready), .in_data(c_data),
    .in_sel(c_sel), .in_bcast(c_bcast),
    .out_valid(a_valid), .out_ready(c_oready), .out_data(a_data),
    .drop_pulse(a_drop), .drop_count(a_count)
  );

  dmux_nway_stream #(.WIDTH(8), .CHANNELS(3), .ERR_W(2)) dut_c3_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_valid), .in_ready(b_ready), .in_data(c_data),
    .in_sel(c_sel), .in_bcast(c_bcast),
    .out_valid(b_valid), .out_ready(c_oready), .out_data(b_data),
    .drop_pulse(b_drop), .drop_count(b_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        v;
    logic [1:0]  sel;
    logic        b;
    logic [7:0]  d;
    logic [3:0]  rdy;
    logic        e_rdy;
    logic [3:0]  e_val;
    logic [31:0] e_dat;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [1:0] sel, input logic b,
                              input logic [7:0] d, input logic [3:0] rdy, input logic e_rdy,
                              input logic [3:0] e_val, input logic [31:0] e_dat);
    vec_t r;
    r.v = v; r.sel = sel; r.b = b; r.d = d; r.rdy = rdy;
    r.e_rdy = e_rdy; r.e_val = e_val; r.e_dat = e_dat;
    return r;
  endfunction

  localparam int NVEC = 14;
  vec_t tbl [NVEC];

  // Reference model: per-channel queue of pending words plus last word shown.
  typedef logic [7:0] byte_q_t[$];
  byte_q_t    mq [4];
  logic [7:0] shown [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Unicast sweep, then backpressure isolation, then broadcast vs stalled ch3.
    tbl[0]  = mk(1, 0, 0, 8'hA0, 4'hF, 1, 4'b0001, 32'h0000_00A0);
    tbl[1]  = mk(1, 1, 0, 8'hA1, 4'hF, 1, 4'b0010, 32'h0000_A1A0);
    tbl[2]  = mk(1, 2, 0, 8'hA2, 4'hF, 1, 4'b0100, 32'h00A2_A1A0);
    tbl[3]  = mk(1, 3, 0, 8'hA3, 4'hF, 1, 4'b1000, 32'hA3A2_A1A0);
    tbl[4]  = mk(0, 0, 0, 8'h00, 4'hF, 1, 4'b0000, 32'hA3A2_A1A0);
    tbl[5]  = mk(1, 2, 0, 8'h11, 4'hB, 1, 4'b0100, 32'hA311_A1A0);
    tbl[6]  = mk(1, 2, 0, 8'h22, 4'hB, 0, 4'b0100, 32'hA311_A1A0);
    tbl[7]  = mk(1, 1, 0, 8'h33, 4'hB, 1, 4'b0110, 32'hA311_33A0);
    tbl[8]  = mk(1, 2, 0, 8'h22, 4'hF, 1, 4'b0100, 32'hA322_33A0);
    tbl[9]  = mk(0, 0, 0, 8'h00, 4'hF, 1, 4'b0000, 32'hA322_33A0);
    tbl[10] = mk(1, 3, 0, 8'h77, 4'h7, 1, 4'b1000, 32'h7722_33A0);
    tbl[11] = mk(1, 0, 1, 8'h5A, 4'h7, 0, 4'b1000, 32'h7722_33A0);
    tbl[12] = mk(1, 0, 1, 8'h5A, 4'hF, 1, 4'b1111, 32'h5A5A_5A5A);
    tbl[13] = mk(0, 0, 0, 8'h00, 4'hF, 1, 4'b0000, 32'h5A5A_5A5A);

    in_valid = 0; in_sel = 0; in_bcast = 0; in_data = 0; out_ready = 4'hF;
    c_valid = 0; c_sel = 0; c_bcast = 0; c_data = 0; c_oready = 3'b000;

    // Reset state
    #1;
    chk("reset out_valid", out_valid, 4'b0000);
    chk("reset out_data", out_data, 32'h0);
    chk("reset drop_pulse", drop_pulse, 1'b0);
    chk("reset drop_count", drop_count, 8'h0);
    chk("reset in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven directed vectors
    for (int i = 0; i < NVEC; i++) begin
      in_valid = tbl[i].v; in_sel = tbl[i].sel; in_bcast = tbl[i].b;
      in_data = tbl[i].d; out_ready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d in_ready", i), in_ready, tbl[i].e_rdy);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("tbl%0d out_valid", i), out_valid, tbl[i].e_val);
      chk($sformatf("tbl%0d out_data", i), out_data, tbl[i].e_dat);
      chk($sformatf("tbl%0d drop_pulse", i), drop_pulse, 1'b0);
    end

    // Async reset while all channels are FULL and stalled
    in_valid = 1; in_bcast = 1; in_sel = 0; in_data = 8'hC3; out_ready = 4'h0;
    @(posedge clk);
    @(negedge clk);
    chk("full before reset", out_valid, 4'b1111);
    in_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", out_valid, 4'b0000);
    chk("async rst out_data", out_data, 32'h0);
    chk("async rst in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1; in_bcast = 0; in_sel = 1; in_data = 8'h99; out_ready = 4'hF;
    #1;
    chk("post rst in_ready", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("post rst out_valid", out_valid, 4'b0010);
    chk("post rst out_data", out_data, 32'h0000_9900);
    in_valid = 0;

    // Out-of-range drops on CHANNELS=3; ERR_W=2 copy saturates at 3
    for (int i = 1; i <= 5; i++) begin
      c_valid = 1; c_sel = 2'd3; c_bcast = 0; c_data = 8'(i); c_oready = 3'b000;
      #1;
      chk($sformatf("oor%0d in_ready", i), a_ready, 1'b1);
      chk($sformatf("oor%0d in_ready sat", i), b_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("oor%0d drop_pulse", i), a_drop, 1'b1);
      chk($sformatf("oor%0d drop_pulse sat", i), b_drop, 1'b1);
      chk($sformatf("oor%0d out_valid", i), a_valid, 3'b000);
      chk($sformatf("oor%0d drop_count", i), a_count, 8'(i));
      chk($sformatf("oor%0d drop_count sat", i), b_count, (i > 3) ? 2'd3 : 2'(i));
    end
    c_valid = 0;
    @(posedge clk);
    @(negedge clk);
    chk("oor idle drop_pulse", a_drop, 1'b0);
    chk("oor final count", a_count, 8'd5);
    chk("oor final count sat", b_count, 2'd3);
    c_valid = 1; c_sel = 2'd2; c_data = 8'h44;
    #1;
    chk("c3 unicast in_ready", a_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("c3 unicast out_valid", a_valid, 3'b100);
    chk("c3 unicast out_data", a_data[23:16], 8'h44);
    chk("c3 unicast no drop", a_drop, 1'b0);
    c_valid = 0;

    // Randomized run against the queue model, starting from reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      shown[k] = 8'h00;
    end
    begin
      logic [3:0]  ct, exp_val, prev_val, prev_rdy;
      logic [31:0] exp_dat, prev_dat;
      logic        exp_rdy, acc;
      prev_val = '0; prev_rdy = '0; prev_dat = '0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_sel    = 2'($urandom);
        in_bcast  = ($urandom_range(0, 7) == 0);
        in_data   = 8'($urandom);
        for (int k = 0; k < 4; k++) out_ready[k] = ($urandom_range(0, 2) != 0);
        #1;
        for (int k = 0; k < 4; k++) begin
          ct[k]      = (mq[k].size() == 0) || out_ready[k];
          exp_val[k] = (mq[k].size() != 0);
          exp_dat[k*8 +: 8] = shown[k];
        end
        exp_rdy = in_bcast ? (&ct) : ct[in_sel];
        chk("rand in_ready", in_ready, exp_rdy);
        chk("rand out_valid", out_valid, exp_val);
        chk("rand out_data", out_data, exp_dat);
        chk("rand drop_pulse", drop_pulse, 1'b0);
        for (int k = 0; k < 4; k++) begin
          if (prev_val[k] && !prev_rdy[k]) begin
            chk("stall hold valid", out_valid[k], 1'b1);
            chk("stall hold data", out_data[k*8 +: 8], prev_dat[k*8 +: 8]);
          end
        end
        prev_val = out_valid; prev_rdy = out_ready; prev_dat = out_data;
        acc = in_valid && exp_rdy;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
          if ((mq[k].size() != 0) && out_ready[k]) void'(mq[k].pop_front());
          if (acc && (in_bcast || (in_sel == 2'(k)))) begin
            mq[k].push_back(in_data);
            shown[k] = in_data;
          end
        end
        @(negedge clk);
      end
    end
    chk("rand drop_count", drop_count, 8'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
